// File: rtl/grain_pkg.sv
// Shared types and constants for the Grain-128 sequencing controller.
package grain_pkg;

    localparam int unsigned KEY_W           = 128;
    localparam int unsigned IV_W            = 96;
    localparam int unsigned SEED_W          = 128;
    localparam int unsigned PAD_W           = SEED_W - IV_W;
    localparam int unsigned INIT_CYCLES_DEF = 256;
    localparam int unsigned LEN_W_DEF       = 16;

    localparam logic [PAD_W-1:0] LFSR_PAD = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INIT = 2'd1,
        RUN  = 2'd2
    } state_e;

    // LFSR seed: all-ones padding above the IV.
    function automatic logic [SEED_W-1:0] lfsr_seed_of(input logic [IV_W-1:0] iv);
        return {LFSR_PAD, iv};
    endfunction

endpackage

// File: rtl/grain_if.sv
// Control/keystream bundle between the cipher top level and the Grain sequencer.
interface grain_if #(
    parameter int unsigned LEN_W = grain_pkg::LEN_W_DEF
);

    logic                          start;
    logic                          abort;
    logic [grain_pkg::KEY_W-1:0]   key;
    logic [grain_pkg::IV_W-1:0]    iv;
    logic [LEN_W-1:0]              len;
    logic                          ks_ready;

    logic [grain_pkg::SEED_W-1:0]  nfsr_seed;
    logic [grain_pkg::SEED_W-1:0]  lfsr_seed;
    logic                          load;
    logic                          shift;
    logic                          init;
    logic                          ks_valid;
    logic                          busy;
    logic                          done;

    modport master (
        output start, abort, key, iv, len, ks_ready,
        input  nfsr_seed, lfsr_seed, load, shift, init, ks_valid, busy, done
    );

    modport slave (
        input  start, abort, key, iv, len, ks_ready,
        output nfsr_seed, lfsr_seed, load, shift, init, ks_valid, busy, done
    );

endinterface

// File: rtl/grain_down_counter.sv
// Loadable down counter with zero/one flags; holds at zero.
module grain_down_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         n_reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero,
    output logic         one
);

    logic [W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (en && (cnt_q != '0)) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == '0);
    assign one  = (cnt_q == W'(1));

endmodule

// File: rtl/grain_ctrl.sv
// Grain-128 sequencer: seeds and loads the shift registers, runs the keyed
// initialisation, then streams the requested number of keystream bits.
module grain_ctrl
    import grain_pkg::*;
#(
    parameter int unsigned INIT_CYCLES = INIT_CYCLES_DEF,
    parameter int unsigned LEN_W       = LEN_W_DEF
) (
    input  logic   clk,
    input  logic   n_reset,
    grain_if.slave bus
);

    localparam int unsigned           ICNT_W    = $clog2(INIT_CYCLES) + 1;
    localparam logic [ICNT_W-1:0]     ICNT_LAST = ICNT_W'(INIT_CYCLES - 1);

    state_e            state_q, state_d;
    logic [ICNT_W-1:0] icnt_q, icnt_d;
    logic              done_q, done_d;

    logic load_c;
    logic shift_c;
    logic init_c;
    logic ks_valid_c;
    logic cnt_load_c;
    logic cnt_en_c;
    logic remain_zero;
    logic remain_one;

    // Remaining-bit count; zero after load means unbounded streaming.
    grain_down_counter #(
        .W (LEN_W)
    ) u_remain (
        .clk      (clk),
        .n_reset  (n_reset),
        .load     (cnt_load_c),
        .load_val (bus.len),
        .en       (cnt_en_c),
        .zero     (remain_zero),
        .one      (remain_one)
    );

    always_comb begin
        state_d    = state_q;
        icnt_d     = icnt_q;
        done_d     = 1'b0;
        load_c     = 1'b0;
        shift_c    = 1'b0;
        init_c     = 1'b0;
        ks_valid_c = 1'b0;
        cnt_load_c = 1'b0;
        cnt_en_c   = 1'b0;

        unique case (state_q)
            IDLE: begin
                // abort beats a simultaneous start
                if (bus.start && !bus.abort) begin
                    load_c     = 1'b1;
                    cnt_load_c = 1'b1;
                    icnt_d     = '0;
                    state_d    = INIT;
                end
            end

            INIT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    shift_c = 1'b1;
                    init_c  = 1'b1;
                    icnt_d  = icnt_q + ICNT_W'(1);
                    if (icnt_q == ICNT_LAST) begin
                        state_d = RUN;
                    end
                end
            end

            RUN: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else begin
                    ks_valid_c = 1'b1;
                    shift_c    = bus.ks_ready;
                    if (bus.ks_ready && !remain_zero) begin
                        if (remain_one) begin
                            state_d = IDLE;
                            done_d  = 1'b1;
                        end else begin
                            cnt_en_c = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q <= IDLE;
            icnt_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            icnt_q  <= icnt_d;
            done_q  <= done_d;
        end
    end

    assign bus.nfsr_seed = bus.key;
    assign bus.lfsr_seed = lfsr_seed_of(bus.iv);
    assign bus.load      = load_c;
    assign bus.shift     = shift_c;
    assign bus.init      = init_c;
    assign bus.ks_valid  = ks_valid_c;
    assign bus.busy      = (state_q != IDLE);
    assign bus.done      = done_q;

endmodule

// File: tb/tb_grain_ctrl.sv
// Scoreboard bench for grain_ctrl: driver queues per-cycle expected controls,
// a negedge monitor pops and compares them against the DUT.
module tb_grain_ctrl;
    import grain_pkg::*;

    typedef struct packed {
        logic [31:0]  tag;
        logic [5:0]   ctl;   // {load, shift, init, ks_valid, busy, done}
        logic         chk;
        logic [127:0] nfsr;
        logic [127:0] lfsr;
    } exp_t;

    localparam logic [5:0] C_IDLE  = 6'b000000;
    localparam logic [5:0] C_LOAD  = 6'b100000;
    localparam logic [5:0] C_INIT  = 6'b011010;
    localparam logic [5:0] C_RUN   = 6'b010110;
    localparam logic [5:0] C_DONE  = 6'b000001;
    localparam logic [5:0] C_ABORT = 6'b000010;

    logic clk = 1'b0;
    logic n_reset;
    always #5 clk = ~clk;

    grain_if #(.LEN_W(16)) bus ();

    grain_ctrl #(
        .INIT_CYCLES (256),
        .LEN_W       (16)
    ) dut (
        .clk     (clk),
        .n_reset (n_reset),
        .bus     (bus)
    );

    exp_t q[$];
    exp_t m_e;
    int   n_cmp    = 0;
    int   n_bad    = 0;
    int   cyc      = 0;
    logic end_chk  = 1'b0;
    logic end_done = 1'b0;
    logic [5:0] act;
    logic rdy [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};

    function automatic exp_t ex(input logic [5:0] c);
        exp_t e;
        e     = '0;
        e.ctl = c;
        return e;
    endfunction

    function automatic exp_t exs(input logic [5:0] c, input logic [127:0] nf, input logic [127:0] lf);
        exp_t e;
        e      = '0;
        e.ctl  = c;
        e.chk  = 1'b1;
        e.nfsr = nf;
        e.lfsr = lf;
        return e;
    endfunction

    // Queue this cycle's expectation, then advance to just after the next edge.
    task automatic step(input exp_t e);
        e.tag = 32'(cyc);
        q.push_back(e);
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic init_phase();
        repeat (256) step(ex(C_INIT));
    endtask

    always @(negedge clk) begin
        if (q.size() != 0) begin
            m_e = q.pop_front();
            act = {bus.load, bus.shift, bus.init, bus.ks_valid, bus.busy, bus.done};
            n_cmp++;
            if (act !== m_e.ctl ||
                (m_e.chk && (bus.nfsr_seed !== m_e.nfsr || bus.lfsr_seed !== m_e.lfsr))) begin
                n_bad++;
                $display("FAIL cycle%0d ctl actual=%b required=%b nfsr actual=%h required=%h lfsr actual=%h required=%h",
                         m_e.tag, act, m_e.ctl, bus.nfsr_seed, m_e.nfsr, bus.lfsr_seed, m_e.lfsr);
            end
        end
        if (end_chk && !end_done) begin
            n_cmp++;
            if (q.size() != 0) begin
                n_bad++;
                $display("FAIL drain leftover actual=%0d required=0", q.size());
            end
            end_done = 1'b1;
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        n_reset      = 1'b0;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.key      = '0;
        bus.iv       = '0;
        bus.len      = '0;
        bus.ks_ready = 1'b0;
        @(posedge clk);
        #1;

        // Reset held, then released idle.
        repeat (3) step(ex(C_IDLE));
        n_reset = 1'b1;
        repeat (5) step(ex(C_IDLE));

        // len=4, zero key/IV, no stalls: done in cycle 261.
        bus.start = 1'b1; bus.key = '0; bus.iv = '0; bus.len = 16'd4; bus.ks_ready = 1'b1;
        step(exs(C_LOAD, 128'h0, 128'hFFFFFFFF_00000000_00000000_00000000));
        bus.start = 1'b0; bus.len = 16'd9;
        init_phase();
        repeat (4) step(ex(C_RUN));
        step(ex(C_DONE));
        repeat (3) step(ex(C_IDLE));

        // len=3 with ready pattern 1,0,0,1,0,1.
        bus.start = 1'b1; bus.len = 16'd3;
        bus.key = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
        bus.iv  = 96'hDEADBEEF_CAFEF00D_12345678;
        step(exs(C_LOAD, 128'h01234567_89ABCDEF_FEDCBA98_76543210,
                 128'hFFFFFFFF_DEADBEEF_CAFEF00D_12345678));
        bus.start = 1'b0;
        init_phase();
        for (int i = 0; i < 6; i++) begin
            bus.ks_ready = rdy[i];
            step(ex({1'b0, rdy[i], 1'b0, 1'b1, 1'b1, 1'b0}));
        end

        // Back-to-back start in the done cycle, unbounded run then abort.
        bus.start = 1'b1; bus.len = 16'd0; bus.ks_ready = 1'b1;
        bus.key = 128'h1; bus.iv = 96'h2;
        step(exs(C_LOAD | C_DONE, 128'h1, 128'hFFFFFFFF_00000000_00000000_00000002));
        bus.start = 1'b0;
        init_phase();
        repeat (1000) step(ex(C_RUN));
        bus.abort = 1'b1;
        step(ex(C_ABORT));
        bus.abort = 1'b0;
        repeat (3) step(ex(C_IDLE));

        // Abort at INIT cycle 100, then a full restart with len=1.
        bus.start = 1'b1; bus.len = 16'd5; bus.key = 128'hA5; bus.iv = 96'h5A;
        step(exs(C_LOAD, 128'hA5, 128'hFFFFFFFF_00000000_00000000_0000005A));
        bus.start = 1'b0;
        repeat (99) step(ex(C_INIT));
        bus.abort = 1'b1;
        step(ex(C_ABORT));
        bus.abort = 1'b0;
        step(ex(C_IDLE));
        bus.start = 1'b1; bus.len = 16'd1;
        step(exs(C_LOAD, 128'hA5, 128'hFFFFFFFF_00000000_00000000_0000005A));
        init_phase();             // start held high here must be ignored
        bus.start = 1'b0;
        step(ex(C_RUN));
        step(ex(C_DONE));
        step(ex(C_IDLE));

        // Simultaneous start and abort: no load.
        bus.start = 1'b1; bus.abort = 1'b1;
        step(ex(C_IDLE));
        bus.start = 1'b0; bus.abort = 1'b0;
        repeat (2) step(ex(C_IDLE));

        // Asynchronous reset mid-RUN.
        bus.start = 1'b1; bus.len = 16'd0;
        step(exs(C_LOAD, 128'hA5, 128'hFFFFFFFF_00000000_00000000_0000005A));
        bus.start = 1'b0;
        init_phase();
        repeat (3) step(ex(C_RUN));
        n_reset = 1'b0;
        repeat (2) step(ex(C_IDLE));
        n_reset = 1'b1;
        repeat (3) step(ex(C_IDLE));

        end_chk = 1'b1;
        @(negedge clk);
        @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
